// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg: shared constants for the execute-stage multiply/divide unit.
//   - MDU_* operation codes driven by the control unit on MDUOp.
//   - Default busy lengths for multiply and divide.
//   - mdu_calc(): combinational 64-bit result {hi, lo} for a cal op.
package mdu_unit_pkg;

  localparam logic [31:0] MDU_default = 32'd0;
  localparam logic [31:0] MDU_mult    = 32'd1;
  localparam logic [31:0] MDU_multu   = 32'd2;
  localparam logic [31:0] MDU_div     = 32'd3;
  localparam logic [31:0] MDU_divu    = 32'd4;
  localparam logic [31:0] MDU_mfhi    = 32'd5;
  localparam logic [31:0] MDU_mflo    = 32'd6;
  localparam logic [31:0] MDU_mthi    = 32'd7;
  localparam logic [31:0] MDU_mtlo    = 32'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Returns {hi, lo}. Multiplies place the product in {hi, lo}; divides put
  // the remainder in hi and the quotient in lo. Divide by zero yields 0 (the
  // caller suppresses the commit in that case anyway).
  function automatic logic [63:0] mdu_calc(input logic [31:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] res;
    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [31:0] quo;
    logic [31:0] rem;
    res  = 64'd0;
    quo  = 32'd0;
    rem  = 32'd0;
    // Sign-extend to 64 bits: the low 64 bits of the product are then exact.
    a_sx = {{32{a[31]}}, a};
    b_sx = {{32{b[31]}}, b};
    case (op)
      MDU_mult:  res = a_sx * b_sx;
      MDU_multu: res = {32'd0, a} * {32'd0, b};
      MDU_div: begin
        if (b == 32'd0) begin
          res = 64'd0;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          // The only signed overflow case: quotient wraps to MIN, remainder 0.
          res = {32'd0, 32'h8000_0000};
        end else begin
          quo = $signed(a) / $signed(b);
          rem = $signed(a) % $signed(b);
          res = {rem, quo};
        end
      end
      MDU_divu: begin
        if (b == 32'd0) begin
          res = 64'd0;
        end else begin
          quo = a / b;
          rem = a % b;
          res = {rem, quo};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// mdu_unit: execute-stage multiply/divide unit holding the HI/LO registers.
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   MDUOp  - operation code (MDU_* from mdu_unit_pkg)
//   A, B   - forwarded rs / rt operands
//   Req    - flush request; suppresses side effects of the current op
//   Start  - a cal op (mult/multu/div/divu) is accepted this cycle
//   Busy   - a multi-cycle operation is in flight (registered)
//   Out    - HI for mfhi, LO for mflo, 0 otherwise
//   HI, LO - architectural HI/LO registers
// The result is computed on the accept cycle and parked in temp registers;
// HI/LO only change on the edge where the busy counter reaches zero.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] Out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_W = 8;

  logic             busy_q,    busy_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [31:0]      hi_q,      hi_d;
  logic [31:0]      lo_q,      lo_d;
  logic [31:0]      temp_hi_q, temp_hi_d;
  logic [31:0]      temp_lo_q, temp_lo_d;
  logic             commit_q,  commit_d;

  logic             is_cal_s;
  logic             is_div_s;
  logic             start_s;
  logic [63:0]      calc_s;
  logic [31:0]      out_s;

  // Decode the op class and the accept condition.
  always_comb begin
    is_cal_s = (MDUOp == MDU_mult) || (MDUOp == MDU_multu) ||
               (MDUOp == MDU_div)  || (MDUOp == MDU_divu);
    is_div_s = (MDUOp == MDU_div)  || (MDUOp == MDU_divu);
    start_s  = is_cal_s && !busy_q && !Req;
    calc_s   = mdu_calc(MDUOp, A, B);
  end

  // Next-state logic for the busy counter, temp result and HI/LO.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    commit_d  = commit_q;
    if (start_s) begin
      busy_d    = 1'b1;
      cnt_d     = is_div_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      temp_hi_d = calc_s[63:32];
      temp_lo_d = calc_s[31:0];
      // A divide by zero still occupies the unit but leaves HI/LO alone.
      commit_d  = !(is_div_s && (B == 32'd0));
    end else if (busy_q) begin
      // An in-flight op belongs to an older instruction: Req does not stop it,
      // and mt/cal ops arriving now are hazard violations and are dropped.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (commit_q) begin
          hi_d = temp_hi_q;
          lo_d = temp_lo_q;
        end else begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      end else begin
        busy_d = 1'b1;
      end
    end else if (!Req && (MDUOp == MDU_mthi)) begin
      hi_d = A;
    end else if (!Req && (MDUOp == MDU_mtlo)) begin
      lo_d = A;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      temp_hi_q <= 32'd0;
      temp_lo_q <= 32'd0;
      commit_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      commit_q  <= commit_d;
    end
  end

  // Read mux for mfhi/mflo; reads the architectural registers only.
  always_comb begin
    case (MDUOp)
      MDU_mfhi: out_s = hi_q;
      MDU_mflo: out_s = lo_q;
      default:  out_s = 32'd0;
    endcase
  end

  assign Start = start_s;
  assign Busy  = busy_q;
  assign Out   = out_s;
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: scoreboard bench for mdu_unit. The stimulus side queues the
// expected {HI, LO, busy length} for every accepted cal op and the expected
// Out value for every read; a negedge monitor pops and compares when the DUT
// shows Start / Busy falling / a read cycle.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] MDUOp = 32'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Req = 1'b0;
  logic        Start;
  logic        Busy;
  logic [31:0] Out;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu_unit dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .A(A), .B(B), .Req(Req),
    .Start(Start), .Busy(Busy), .Out(Out), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  exp_t        cal_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  logic [31:0] pend_hi = 32'd0;
  logic [31:0] pend_lo = 32'd0;
  bit          pend_v = 1'b0;
  bit          inflight = 1'b0;
  bit          rd_en = 1'b0;
  int          bcnt = 0;
  exp_t        cur;

  function automatic bit is_cal(input logic [31:0] op);
    return (op == MDU_mult) || (op == MDU_multu) || (op == MDU_div) || (op == MDU_divu);
  endfunction

  // Reference arithmetic from the architectural definition, in 64-bit integers.
  function automatic logic [63:0] ref_calc(input logic [31:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    if (op == MDU_mult) begin
      p = sa * sb;
    end else if (op == MDU_multu) begin
      p = ua * ub;
    end else if (op == MDU_div) begin
      sq = sa / sb;
      sr = sa % sb;
      q  = sq;
      r  = sr;
      p  = {r[31:0], q[31:0]};
    end else begin
      uq = ua / ub;
      ur = ua % ub;
      q  = uq;
      r  = ur;
      p  = {r[31:0], q[31:0]};
    end
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic req);
    MDUOp = op;
    A     = a;
    B     = b;
    Req   = req;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cal(input logic [31:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic req);
    logic [63:0] p;
    exp_t        e;
    if (!req) begin
      if (((op == MDU_div) || (op == MDU_divu)) && (b == 32'd0)) begin
        e.hi = model_hi;
        e.lo = model_lo;
      end else begin
        p    = ref_calc(op, a, b);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      e.len   = ((op == MDU_div) || (op == MDU_divu)) ? DIV_CYCLES_DEF : MULT_CYCLES_DEF;
      cal_q.push_back(e);
      pend_hi = e.hi;
      pend_lo = e.lo;
      pend_v  = 1'b1;
    end
    drive(op, a, b, req);
    tick();
    drive(MDU_default, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((inflight || Busy) && (n < 40)) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      errors++;
      $display("FAIL busy_timeout: Busy still 1 after %0d cycles, expected 0", n);
    end
    if (pend_v) begin
      model_hi = pend_hi;
      model_lo = pend_lo;
      pend_v   = 1'b0;
    end
  endtask

  task automatic mt(input logic [31:0] op, input logic [31:0] a, input logic req);
    drive(op, a, 32'd0, req);
    tick();
    drive(MDU_default, 32'd0, 32'd0, 1'b0);
    if (!req) begin
      if (op == MDU_mthi) model_hi = a;
      else model_lo = a;
    end
  endtask

  task automatic rd(input logic [31:0] op);
    logic [31:0] e;
    e = (op == MDU_mfhi) ? model_hi : ((op == MDU_mflo) ? model_lo : 32'd0);
    rd_q.push_back(e);
    rd_en = 1'b1;
    drive(op, $urandom, $urandom, 1'b0);
    tick();
    rd_en = 1'b0;
    drive(MDU_default, 32'd0, 32'd0, 1'b0);
  endtask

  // Monitor: matches Start/commit and read cycles against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      inflight = 1'b0;
    end else begin
      if (inflight) begin
        if (Busy) begin
          bcnt++;
        end else begin
          chk("busy_len", 32'(bcnt), 32'(cur.len));
          chk("commit_hi", HI, cur.hi);
          chk("commit_lo", LO, cur.lo);
          inflight = 1'b0;
        end
      end
      if (Start) begin
        if (Busy) begin
          errors++;
          $display("FAIL start_while_busy: Start=1 Busy=1, expected Start=0");
        end
        if (cal_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: Start=1 op=%0d, expected Start=0", MDUOp);
        end else begin
          cur      = cal_q.pop_front();
          inflight = 1'b1;
          bcnt     = 0;
        end
      end
      if (rd_en && (rd_q.size() > 0)) begin
        chk("out", Out, rd_q.pop_front());
      end
      if (Busy && is_cal(MDUOp)) begin
        errors++;
        $display("FAIL hazard: cal op %0d issued while Busy=1, expected none", MDUOp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] op, a, b;
    logic        req;
    int          k;
    drive(MDU_default, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_start", 32'(Start), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_out", Out, 32'd0);
    reset = 1'b1;
    tick();

    issue_cal(MDU_mult,  32'hFFFF_FFFF, 32'h2, 1'b0); wait_done(); rd(MDU_mfhi); rd(MDU_mflo);
    issue_cal(MDU_multu, 32'hFFFF_FFFF, 32'h2, 1'b0); wait_done(); rd(MDU_mfhi); rd(MDU_mflo);
    issue_cal(MDU_div,   32'hFFFF_FFF9, 32'h2, 1'b0); wait_done(); rd(MDU_mfhi); rd(MDU_mflo);
    issue_cal(MDU_divu,  32'h7,         32'h2, 1'b0); wait_done(); rd(MDU_mfhi); rd(MDU_mflo);
    issue_cal(MDU_div,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_done(); rd(MDU_mfhi); rd(MDU_mflo);

    // Divide by zero keeps the preloaded HI/LO.
    mt(MDU_mthi, 32'h11, 1'b0);
    mt(MDU_mtlo, 32'h22, 1'b0);
    issue_cal(MDU_divu, 32'h5, 32'h0, 1'b0); wait_done(); rd(MDU_mfhi); rd(MDU_mflo);

    // Flushed mult and flushed mtlo have no effect.
    issue_cal(MDU_mult, 32'h3, 32'h3, 1'b1);
    chk("req_busy", 32'(Busy), 32'd0);
    wait_done(); rd(MDU_mfhi); rd(MDU_mflo);
    mt(MDU_mtlo, 32'h55, 1'b1); rd(MDU_mflo);

    // Req in the middle of a run does not disturb it; the mtlo is dropped.
    issue_cal(MDU_mult, 32'h3, 32'h4, 1'b0);
    tick();
    drive(MDU_mtlo, 32'h99, 32'd0, 1'b1);
    tick();
    tick();
    drive(MDU_default, 32'd0, 32'd0, 1'b0);
    wait_done(); rd(MDU_mflo); rd(MDU_mfhi);

    mt(MDU_mthi, 32'h1234, 1'b0); rd(MDU_mfhi);

    // mflo during a run returns the old LO.
    issue_cal(MDU_mult, 32'h10, 32'h10, 1'b0);
    rd(MDU_mflo); rd(MDU_mfhi);
    wait_done(); rd(MDU_mflo);
    rd(MDU_default);
    rd(32'h0000_00FF);

    // Reset mid-run: everything clears and no late commit appears.
    issue_cal(MDU_mult, 32'h5, 32'h6, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    cal_q.delete();
    pend_v   = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    #1;
    chk("rst_mid_busy", 32'(Busy), 32'd0);
    chk("rst_mid_hi", HI, 32'd0);
    chk("rst_mid_lo", LO, 32'd0);
    tick();
    reset = 1'b1;
    repeat (12) tick();
    chk("post_rst_busy", 32'(Busy), 32'd0);
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd0);

    // Randomized mix of all operations.
    for (int i = 0; i < 40; i++) begin
      k   = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      req = ($urandom_range(0, 7) == 0);
      op  = 32'(k + 1);
      if (is_cal(op)) begin
        if ((op == MDU_div || op == MDU_divu) && ($urandom_range(0, 5) == 0)) b = 32'd0;
        if ((op == MDU_div || op == MDU_divu) && ($urandom_range(0, 3) == 0)) b = 32'($urandom_range(1, 9));
        issue_cal(op, a, b, req);
        wait_done();
        rd(MDU_mfhi);
        rd(MDU_mflo);
      end else if ((op == MDU_mthi) || (op == MDU_mtlo)) begin
        mt(op, a, req);
        rd((op == MDU_mthi) ? MDU_mfhi : MDU_mflo);
      end else begin
        rd(op);
      end
    end

    repeat (2) tick();
    checks++;
    if ((cal_q.size() != 0) || inflight) begin
      errors++;
      $display("FAIL leftover: %0d pending ops, expected 0", cal_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
